// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU port and an I/O (DMA) port share one memory.
// Each transfer runs IDLE -> ACCESS -> RESP, giving one transfer per three cycles.
// By default the CPU has priority, and the I/O port is promoted after STARVE_LIMIT losses in a row.
// Define ARB_ROUND_ROBIN_EN to alternate between the ports when both request at once.
module mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [0:ADDR_W-1] cpu_addr_i,
  input  logic [0:DATA_W-1] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [0:DATA_W-1] cpu_rdata_o,
  input  logic              io_req_i,
  input  logic              io_we_i,
  input  logic [0:ADDR_W-1] io_addr_i,
  input  logic [0:DATA_W-1] io_wdata_i,
  output logic              io_ack_o,
  output logic [0:DATA_W-1] io_rdata_o,
  output logic              mem_r_line_o,
  output logic              mem_w_line_o,
  output logic [0:ADDR_W-1] mem_add_line_o,
  output logic [0:DATA_W-1] mem_wdata_o,
  input  logic [0:DATA_W-1] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q;
  logic                ownerIo_q;
  logic                isWrite_q;
  logic [0:ADDR_W-1]   addr_q;
  logic [0:DATA_W-1]   wdata_q;
  logic                memRead_q;
  logic                memWrite_q;
  logic                cpuAck_q;
  logic                ioAck_q;
  logic [0:DATA_W-1]   cpuRdata_q;
  logic [0:DATA_W-1]   ioRdata_q;

  logic                anyReq;
  logic                grantIo_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the I/O port holds priority for the next simultaneous request.
  logic                rrIoFirst_q;
  logic                rrIoFirst_d;
`else
  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
  logic [3:0]          starveCnt_q;
  logic [3:0]          starveCnt_d;
`endif

  // Arbitration decision for the current IDLE cycle, along with the next value of the fairness state.
  always_comb begin
    anyReq = cpu_req_i | io_req_i;
`ifdef ARB_ROUND_ROBIN_EN
    grantIo_d   = io_req_i & (~cpu_req_i | rrIoFirst_q);
    rrIoFirst_d = rrIoFirst_q;
    if (anyReq) begin
      rrIoFirst_d = ~grantIo_d;
    end
`else
    grantIo_d   = io_req_i & (~cpu_req_i | (starveCnt_q == StarveLim));
    starveCnt_d = starveCnt_q;
    if (!io_req_i || grantIo_d) begin
      starveCnt_d = 4'd0;
    end else if (starveCnt_q != StarveLim) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end
`endif
  end

  // Transfer FSM. All outputs are registered, and reset aborts any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ownerIo_q   <= 1'b0;
      isWrite_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      cpuAck_q    <= 1'b0;
      ioAck_q     <= 1'b0;
      cpuRdata_q  <= '0;
      ioRdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rrIoFirst_q <= 1'b0;
`else
      starveCnt_q <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
          starveCnt_q <= starveCnt_d;
`endif
          if (anyReq) begin
`ifdef ARB_ROUND_ROBIN_EN
            rrIoFirst_q <= rrIoFirst_d;
`endif
            ownerIo_q  <= grantIo_d;
            isWrite_q  <= grantIo_d ? io_we_i : cpu_we_i;
            addr_q     <= grantIo_d ? io_addr_i : cpu_addr_i;
            wdata_q    <= grantIo_d ? io_wdata_i : cpu_wdata_i;
            memRead_q  <= grantIo_d ? ~io_we_i : ~cpu_we_i;
            memWrite_q <= grantIo_d ? io_we_i : cpu_we_i;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          memRead_q  <= 1'b0;
          memWrite_q <= 1'b0;
          if (!isWrite_q) begin
            if (ownerIo_q) begin
              ioRdata_q <= mem_rdata_i;
            end else begin
              cpuRdata_q <= mem_rdata_i;
            end
          end
          cpuAck_q <= ~ownerIo_q;
          ioAck_q  <= ownerIo_q;
          state_q  <= RESP;
        end
        RESP: begin
          cpuAck_q <= 1'b0;
          ioAck_q  <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ack_o      = cpuAck_q;
  assign io_ack_o       = ioAck_q;
  assign cpu_rdata_o    = cpuRdata_q;
  assign io_rdata_o     = ioRdata_q;
  assign mem_r_line_o   = memRead_q;
  assign mem_w_line_o   = memWrite_q;
  assign mem_add_line_o = addr_q;
  assign mem_wdata_o    = wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 ADDR_W, 12, address width; buses use MSB-first [0:N-1] ordering.
REQ-002 DATA_W, 16, data width.
REQ-003 STARVE_LIMIT, 4, consecutive IO losses before IO is promoted; legal 1..15.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 CPU_REQ  input  1  CPU requests one memory transfer; held high until CPU_ACK.
REQ-007 CPU_WE  input  1  1 = write, 0 = read.
REQ-008 CPU_ADDR  input  ADDR_W  CPU transfer address.
REQ-009 CPU_WDATA  input  DATA_W  CPU write data.
REQ-010 CPU_ACK  output  1  one-cycle pulse: CPU transfer complete.
REQ-011 CPU_RDATA  output  DATA_W  CPU read result, valid with CPU_ACK, held until the next CPU read completes.
REQ-012 IO_REQ  input  1  I/O (DMA) request; same rules as CPU_REQ.
REQ-013 IO_WE  input  1  1 = write, 0 = read.
REQ-014 IO_ADDR  input  ADDR_W  I/O transfer address.
REQ-015 IO_WDATA  input  DATA_W  I/O write data.
REQ-016 IO_ACK  output  1  one-cycle pulse: I/O transfer complete.
REQ-017 IO_RDATA  output  DATA_W  I/O read result; same rules as CPU_RDATA.
REQ-018 MEM_r_line  output  1  memory read strobe.
REQ-019 MEM_w_line  output  1  memory write strobe.
REQ-020 MEM_add_line  output  ADDR_W  memory address.
REQ-021 MEM_wdata  output  DATA_W  memory write data.
REQ-022 MEM_rdata  input  DATA_W  memory read data; combinationally valid while MEM_r_line is high.

Function
REQ-023 FSM states: IDLE, ACCESS, RESP.
REQ-024 Sequence: IDLE -> ACCESS -> RESP -> IDLE.
REQ-025 IDLE: at an edge with any REQ high, the arbiter latches the winner's ADDR/WE/WDATA and owner ID, then moves to ACCESS; otherwise it stays in IDLE.
REQ-026 ACCESS lasts exactly one cycle.
REQ-027 During ACCESS, MEM_r_line = !WE and MEM_w_line = WE, driven from the latched values.
REQ-028 At the ACCESS->RESP edge, a read captures MEM_rdata into the owner's RDATA; a write leaves RDATA unchanged.
REQ-029 RESP lasts one cycle with the owner's ACK = 1, then returns to IDLE.
REQ-030 Latency: REQ sampled in IDLE at cycle n -> ACCESS in cycle n+1 -> ACK in cycle n+2.
REQ-031 Throughput: at most one transfer per 3 cycles.
REQ-032 REQ values seen during ACCESS or RESP are ignored.
REQ-033 A REQ still high in the IDLE cycle after its ACK counts as a new request.
REQ-034 Deasserting REQ before ACK does not abort the transfer; ACK is still pulsed.
REQ-035 Single requester: that requester always wins.
REQ-036 Both requesting: CPU wins, unless the starvation counter equals STARVE_LIMIT, in which case IO wins.
REQ-037 Starvation counter, 4-bit: +1 when IO_REQ = 1 and CPU wins. Cleared when IO is granted or when IO_REQ = 0 in IDLE. Saturates at STARVE_LIMIT.
REQ-038 CPU_ACK and IO_ACK are registered and are never high in the same cycle.
REQ-039 MEM_r_line and MEM_w_line are never both high; both are 0 outside ACCESS.
REQ-040 MEM_add_line and MEM_wdata hold their last latched values outside ACCESS.

Reset
REQ-041 RESET = 1 at an edge overrides all other inputs and sets:
  - state = IDLE
  - ACKs, MEM strobes, MEM_add_line, MEM_wdata = 0
  - both RDATA = 0, latched address/data = 0
  - starvation counter = 0, round-robin pointer = CPU
REQ-042 RESET during ACCESS or RESP aborts the transfer: no ACK, and strobes are 0 in the next cycle.

Configuration
REQ-043 ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester not granted last wins. The pointer updates on every grant. The starvation counter and STARVE_LIMIT have no effect.
REQ-044 ARB_ROUND_ROBIN_EN undefined: fixed CPU priority with starvation promotion per REQ-036/037.

Verification
REQ-045 CPU read: CPU_REQ = 1, CPU_WE = 0, CPU_ADDR = 0x010, memory[0x010] = 0x1234 -> MEM_r_line = 1 in cycle n+1; CPU_ACK = 1 and CPU_RDATA = 0x1234 in cycle n+2.
REQ-046 IO write: IO_ADDR = 0x3FF, IO_WDATA = 0xBEEF -> MEM_w_line = 1, MEM_add_line = 0x3FF, MEM_wdata = 0xBEEF for exactly one cycle; IO_ACK pulses once; IO_RDATA unchanged.
REQ-047 Both REQ held high continuously, STARVE_LIMIT = 4, macro undefined -> grant order CPU, CPU, CPU, CPU, IO, CPU, ...; ACKs never overlap.
REQ-048 Same stimulus with ARB_ROUND_ROBIN_EN defined -> grant order CPU, IO, CPU, IO, ...
REQ-049 RESET asserted during ACCESS of a CPU read -> no CPU_ACK; all outputs 0 in the next cycle; a CPU request issued afterwards completes with 3-cycle latency.
